// File: rtl/fasm_spsram_wb.sv
// Single-port synchronous RAM with byte-lane writes, an optional output register,
// a selectable read-during-write mode, ack handshake and a post-reset clear sequencer.
module fasm_spsram_wb #(
  parameter int AW         = 8,
  parameter int DW         = 32,
  parameter int REG_OUT    = 0,
  parameter int RDW_MODE   = 0,
  parameter int CLR_ON_RST = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             stb_i,
  input  logic             wre_i,
  input  logic [DW/8-1:0]  sel_i,
  input  logic [AW-1:0]    adr_i,
  input  logic [DW-1:0]    dat_i,
  output logic [DW-1:0]    dat_o,
  output logic             ack_o,
  output logic             busy_o
);

  localparam int SW = DW / 8;

  // Handshake: a request is taken on any rising edge where stb_i = 1 and the
  // sequencer is READY; there is no backpressure, and each taken request
  // produces exactly one ack_o pulse 1 + REG_OUT cycles later, in order.

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
  logic          clr_we;
  logic          acc;

  reg   [DW-1:0] mem [0:2**AW-1];
  logic [DW-1:0] rd_q;

  logic          v1_q;
  logic          wre1_q;
  logic [SW-1:0] sel1_q;
  logic [DW-1:0] dat1_q;
  logic          seen_q;
  logic [DW-1:0] word1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= (CLR_ON_RST != 0) ? S_CLEAR : S_READY;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    clr_we    = 1'b0;
    case (state_q)
      S_CLEAR: begin
        clr_we    = 1'b1;
        clr_cnt_d = clr_cnt_q + AW'(1);
        if (clr_cnt_q == {AW{1'b1}}) state_d = S_READY;
      end
      default: ;
    endcase
  end

  assign busy_o = (state_q == S_CLEAR);
  assign acc    = stb_i && (state_q == S_READY);

  // Array port: the read always sees the word before any write on the same edge,
  // so write-first data is rebuilt from the old word plus the registered lanes.
  always_ff @(posedge clk_i) begin
    if (clr_we) begin
      mem[clr_cnt_q] <= '0;
    end else if (acc && wre_i) begin
      for (int n = 0; n < SW; n++) begin
        if (sel_i[n]) mem[adr_i][n*8 +: 8] <= dat_i[n*8 +: 8];
      end
    end
    if (acc) rd_q <= mem[adr_i];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v1_q   <= 1'b0;
      wre1_q <= 1'b0;
      sel1_q <= '0;
      dat1_q <= '0;
      seen_q <= 1'b0;
    end else begin
      v1_q <= acc;
      if (acc) begin
        wre1_q <= wre_i;
        sel1_q <= sel_i;
        dat1_q <= dat_i;
        seen_q <= 1'b1;
      end
    end
  end

  always_comb begin
    word1 = rd_q;
    if (RDW_MODE == 0 && wre1_q) begin
      for (int n = 0; n < SW; n++) begin
        if (sel1_q[n]) word1[n*8 +: 8] = dat1_q[n*8 +: 8];
      end
    end
  end

  generate
    if (REG_OUT == 0) begin : g_direct
      // word1 only changes on an accepting edge, so it already holds between acks.
      assign ack_o = v1_q;
      assign dat_o = seen_q ? word1 : '0;
    end else begin : g_reg
      logic          ack_q;
      logic [DW-1:0] dat_q;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          ack_q <= 1'b0;
          dat_q <= '0;
        end else begin
          ack_q <= v1_q;
          if (v1_q) dat_q <= word1;
        end
      end

      assign ack_o = ack_q;
      assign dat_o = dat_q;
    end
  endgenerate

endmodule

// File: tb/tb_fasm_spsram_wb.sv
// Directed bench for fasm_spsram_wb: two instances (latency 1 write-first,
// latency 2 read-first) share the request bus; acks are scored against queues.
module tb_fasm_spsram_wb;

  logic        clk;
  logic        rst_n;
  logic        stb;
  logic        wre;
  logic [3:0]  sel;
  logic [3:0]  adr;
  logic [31:0] dat;
  logic [31:0] dat0, dat1;
  logic        ack0, ack1;
  logic        busy0, busy1;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  int          cyc_q0[$];
  int          cyc_q1[$];
  logic [31:0] last0 = '0;
  logic [31:0] last1 = '0;

  fasm_spsram_wb #(.AW(4), .DW(32), .REG_OUT(0), .RDW_MODE(0), .CLR_ON_RST(1)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .stb_i(stb), .wre_i(wre), .sel_i(sel),
    .adr_i(adr), .dat_i(dat), .dat_o(dat0), .ack_o(ack0), .busy_o(busy0)
  );

  fasm_spsram_wb #(.AW(4), .DW(32), .REG_OUT(1), .RDW_MODE(1), .CLR_ON_RST(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .stb_i(stb), .wre_i(wre), .sel_i(sel),
    .adr_i(adr), .dat_i(dat), .dat_o(dat1), .ack_o(ack1), .busy_o(busy1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // driver: present one request for one cycle; e0/e1 are the ack data expected
  // from the write-first/latency-1 and read-first/latency-2 instances.
  task automatic req(input logic w, input logic [3:0] s, input logic [3:0] a,
                     input logic [31:0] d, input logic [31:0] e0, input logic [31:0] e1);
    stb = 1'b1; wre = w; sel = s; adr = a; dat = d;
    exp_q0.push_back(e0); cyc_q0.push_back(cyc + 1);
    exp_q1.push_back(e1); cyc_q1.push_back(cyc + 2);
    @(negedge clk);
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] e);
    req(1'b0, 4'($urandom_range(15, 0)), a, $urandom, e, e);
  endtask

  task automatic idle(input int n);
    stb = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // scoreboard: every ack must match the head of its queue, in data and cycle;
  // between acks dat_o must hold the last acked word.
  always @(negedge clk) begin
    if (ack0) begin
      if (exp_q0.size() == 0) check("ack0_unexpected", 32'd1, 32'd0);
      else begin
        last0 = exp_q0.pop_front();
        check("dat0", dat0, last0);
        check("lat0", cyc, cyc_q0.pop_front());
      end
    end else check("hold0", dat0, last0);
    if (ack1) begin
      if (exp_q1.size() == 0) check("ack1_unexpected", 32'd1, 32'd0);
      else begin
        last1 = exp_q1.pop_front();
        check("dat1", dat1, last1);
        check("lat1", cyc, cyc_q1.pop_front());
      end
    end else check("hold1", dat1, last1);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b0; stb = 1'b0; wre = 1'b0; sel = '0; adr = '0; dat = '0;
    repeat (3) @(negedge clk);
    check("rst_busy0", busy0, 1);
    check("rst_busy1", busy1, 1);
    check("rst_ack0", ack0, 0);
    check("rst_ack1", ack1, 0);
    check("rst_dat0", dat0, 0);
    check("rst_dat1", dat1, 0);

    // release, then reset again with the clear counter at 7
    rst_n = 1'b1;
    repeat (7) @(posedge clk);
    @(negedge clk);
    check("midclr_busy", busy0, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midclr_rst_busy", busy0, 1);
    rst_n = 1'b1;

    // full clear must rerun; a write offered while busy is dropped
    stb = 1'b1; wre = 1'b1; sel = 4'hF; adr = 4'd2; dat = 32'hFFFF_FFFF;
    n = 0;
    while (busy0 && n < 100) begin
      n++;
      if (n == 3) stb = 1'b0;
      @(negedge clk);
    end
    stb = 1'b0;
    check("clr_len", n, 16);
    check("clr_busy1_done", busy1, 0);

    for (int i = 0; i < 16; i++) rd(4'(i), 32'h0000_0000);

    // full write then read-after-write on the next cycle
    req(1'b1, 4'hF, 4'd3, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_0000);
    rd(4'd3, 32'hDEAD_BEEF);
    // partial lanes 0 and 2
    req(1'b1, 4'b0101, 4'd3, 32'h1122_3344, 32'hDE22_BE44, 32'hDEAD_BEEF);
    rd(4'd3, 32'hDE22_BE44);
    // read-during-write modes
    req(1'b1, 4'hF, 4'd5, 32'hAAAA_5555, 32'hAAAA_5555, 32'h0000_0000);
    idle(2);
    req(1'b1, 4'hF, 4'd5, 32'h1234_5678, 32'h1234_5678, 32'hAAAA_5555);
    // no lanes enabled: no change, acks current word
    req(1'b1, 4'h0, 4'd5, 32'hFFFF_FFFF, 32'h1234_5678, 32'h1234_5678);
    rd(4'd5, 32'h1234_5678);
    rd(4'd3, 32'hDE22_BE44);
    idle(3);

    // back-to-back writes and reads on consecutive cycles
    for (int i = 8; i < 16; i++)
      req(1'b1, 4'hF, 4'(i), 32'hC0DE_0000 | 32'(i), 32'hC0DE_0000 | 32'(i), 32'h0000_0000);
    for (int i = 8; i < 16; i++) rd(4'(i), 32'hC0DE_0000 | 32'(i));
    rd(4'd2, 32'h0000_0000);
    idle(5);

    check("q0_drained", exp_q0.size(), 0);
    check("q1_drained", exp_q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
